parity_checker_rx: RTL and testbench
====================================

Name: parity_checker_rx

Overview:
- Serial receive-side counterpart of the team's parity generator.
- Accepts a frame of DATA_W data bits followed by one parity bit over a valid-qualified serial input.
- Reassembles the data word and checks parity against the configured even/odd mode.
- Reports each frame with a one-cycle pulse and keeps a saturating error count for status readout.

Parameters:
- DATA_W, 8, data bits per frame; legal range 1 to 32.
- PARITY_ODD, 0, 0 = even parity (XOR of data and parity bits is 0); 1 = odd parity (XOR is 1).
- CNT_W, 8, width of the saturating parity-error counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- bit_in  input  1  serial data/parity bit.
- bit_valid  input  1  bit_in is consumed on this cycle.
- frame_start  input  1  qualified by bit_valid; marks the first data bit of a frame.
- clr_count  input  1  synchronous clear of err_count.
- data_out  output  DATA_W  last received data word, LSB first on the wire.
- data_valid  output  1  one-cycle pulse: data_out is updated and the frame is complete.
- parity_err  output  1  one-cycle pulse coincident with data_valid when the parity check fails.
- busy  output  1  high while a frame is in progress (states DATA or PARITY).
- err_count  output  CNT_W  saturating count of failed frames.

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE.
  - data_out = 0, data_valid = 0, parity_err = 0, busy = 0, err_count = 0.
  - Shift register, bit counter and running parity cleared.
- Bit acceptance: a bit is taken only on a rising clk edge with bit_valid = 1. bit_valid = 0 holds all state, so arbitrary gaps between bits are legal.
- State IDLE:
  - bit_valid & frame_start: store bit_in as data bit 0, load running parity = bit_in, bit count = 1, go to DATA (or PARITY if DATA_W = 1).
  - bit_valid without frame_start: bit is ignored, stay in IDLE.
- State DATA:
  - Each accepted bit is stored at index = bit count (LSB first) and XORed into running parity; count increments.
  - After bit DATA_W-1 is accepted, go to PARITY.
- State PARITY:
  - On the accepted bit, final = running parity XOR bit_in XOR PARITY_ODD.
  - Next cycle: data_out = assembled word, data_valid = 1, parity_err = (final != 0). Return to IDLE.
- Latency: outputs are registered and appear exactly 1 cycle after the parity bit is accepted. data_out holds its value until the next completed frame.
- Restart: frame_start with bit_valid while in DATA or PARITY:
  - The current frame is abandoned with no data_valid and no count change.
  - That bit becomes data bit 0 of the new frame, same as in IDLE.
- Back-to-back frames: frame_start may arrive on the cycle immediately after the parity bit. The new frame begins while data_valid is pulsing for the previous one.
- err_count:
  - Increments by 1 on each parity_err pulse and saturates at all-ones with no wrap.
  - clr_count sets it to 0 on the next edge. If clr_count coincides with an error, clear wins and the result is 0.
- Reset mid-frame: the partial frame is discarded; no pulse is generated after reset release.
- Arithmetic: bit counter is clog2(DATA_W+1) bits wide. Parity is computed incrementally and never recomputed from data_out.

Decomposition:
- Shared package parity_pkg holds:
  - state enum {IDLE, DATA, PARITY};
  - constants PARITY_EVEN = 0 and PARITY_ODD = 1, shared with the generator.
- One natural sub-module: sat_counter (parameterised width, inc, clr with clear priority), reusable elsewhere for status counters.
- Shift/parity datapath stays inline.

Test Plan:
- Even mode, DATA_W=8: send 0xA5 LSB first (1,0,1,0,0,1,0,1) with frame_start on the first bit, then parity 0 -> data_out=0xA5, data_valid pulse, parity_err=0, err_count=0.
- Same frame with parity bit 1 -> data_valid and parity_err pulse together, err_count=1. Repeat with PARITY_ODD=1 and parity 1 -> parity_err=0.
- Gaps: 0x3C with bit_valid deasserted 3 cycles between each bit, parity 0 -> single data_valid 1 cycle after the parity bit, data_out=0x3C; busy high throughout the frame.
- Restart: 4 bits of a frame, then frame_start with a fresh 0xFF frame, parity 0 -> exactly one data_valid, data_out=0xFF, parity_err=0.
- Saturation and clear, CNT_W=2: 5 bad-parity frames -> err_count reads 1, 2, 3, 3, 3. Then clr_count coincident with a 6th bad frame -> err_count=0.
- Reset mid-frame: pulse rst_n low after 5 data bits -> all outputs 0 immediately. Remaining bits sent without frame_start are ignored: no data_valid, busy=0.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity generator/checker pair.
package parity_pkg;

  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity
  } state_e;

  // Final check bit: zero means the frame matches the configured mode.
  function automatic logic final_parity(logic running, logic last_bit, logic odd_mode);
    return running ^ last_bit ^ odd_mode;
  endfunction

endpackage

// File: rtl/parity_checker_rx_if.sv
// Serial receive bus: sender drives bits/controls, checker returns frame results and status.
interface parity_checker_rx_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
);

  logic              bit_in;
  logic              bit_valid;
  logic              frame_start;
  logic              clr_count;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              busy;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output bit_in,
    output bit_valid,
    output frame_start,
    output clr_count,
    input  data_out,
    input  data_valid,
    input  parity_err,
    input  busy,
    input  err_count
  );

  modport slave (
    input  bit_in,
    input  bit_valid,
    input  frame_start,
    input  clr_count,
    output data_out,
    output data_valid,
    output parity_err,
    output busy,
    output err_count
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/parity_checker_rx.sv
// Serial frame receiver: reassembles DATA_W bits LSB first, checks the trailing parity bit,
// pulses data_valid/parity_err one cycle later and keeps a saturating error count.
module parity_checker_rx #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          PARITY_ODD = parity_pkg::PARITY_EVEN,
  parameter int unsigned CNT_W      = 8
) (
  input logic                clk,
  input logic                rst_n,
  parity_checker_rx_if.slave bus
);

  import parity_pkg::*;

  localparam int unsigned BitCntW = $clog2(DATA_W + 1);
  localparam bit          OddMode = (PARITY_ODD == parity_pkg::PARITY_ODD);

  state_e              state_q;
  logic [DATA_W-1:0]   shift_q;
  logic [DATA_W-1:0]   data_q;
  logic [BitCntW-1:0]  cnt_q;
  logic                par_q;
  logic                valid_q;
  logic                err_q;

  logic take;
  logic start;
  logic final_bit;
  logic err_inc;

  assign take      = bus.bit_valid;
  assign start     = take & bus.frame_start;
  assign final_bit = final_parity(par_q, bus.bit_in, OddMode);
  // Count on the same edge that launches the parity_err pulse.
  assign err_inc   = take & ~bus.frame_start & (state_q == StParity) & final_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (start) begin
        // A start bit always opens a fresh frame, abandoning any partial one.
        shift_q <= DATA_W'(bus.bit_in);
        par_q   <= bus.bit_in;
        cnt_q   <= BitCntW'(1);
        state_q <= (DATA_W == 1) ? StParity : StData;
      end else if (take) begin
        case (state_q)
          StData: begin
            for (int unsigned i = 1; i < DATA_W; i++) begin
              if (cnt_q == BitCntW'(i)) begin
                shift_q[i] <= bus.bit_in;
              end
            end
            par_q <= par_q ^ bus.bit_in;
            cnt_q <= cnt_q + BitCntW'(1);
            if (cnt_q == BitCntW'(DATA_W - 1)) begin
              state_q <= StParity;
            end
          end
          StParity: begin
            data_q  <= shift_q;
            valid_q <= 1'b1;
            err_q   <= final_bit;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (err_inc),
    .clr  (bus.clr_count),
    .count(bus.err_count)
  );

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = err_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_parity_checker_rx.sv
// Directed bench: an even-parity checker (2-bit error count) and an odd-parity checker share
// one serial stimulus stream; expectations are hand-computed per frame.
module tb_parity_checker_rx;

  logic clk;
  logic rst_n;
  logic bit_in;
  logic bit_valid;
  logic frame_start;
  logic clr_count;

  int n_total = 0;
  int n_bad   = 0;
  int dv_seen = 0;
  int mark;

  parity_checker_rx_if #(.DATA_W(8), .CNT_W(2)) ife ();
  parity_checker_rx_if #(.DATA_W(8), .CNT_W(8)) ifo ();

  assign ife.bit_in      = bit_in;
  assign ife.bit_valid   = bit_valid;
  assign ife.frame_start = frame_start;
  assign ife.clr_count   = clr_count;
  assign ifo.bit_in      = bit_in;
  assign ifo.bit_valid   = bit_valid;
  assign ifo.frame_start = frame_start;
  assign ifo.clr_count   = clr_count;

  parity_checker_rx #(
    .DATA_W    (8),
    .PARITY_ODD(1'b0),
    .CNT_W     (2)
  ) dut_even (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ife)
  );

  parity_checker_rx #(
    .DATA_W    (8),
    .PARITY_ODD(1'b1),
    .CNT_W     (8)
  ) dut_odd (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ife.data_valid) dv_seen <= dv_seen + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the bit is consumed at the following posedge.
  task automatic put(input logic b, input logic fs);
    bit_in      = b;
    frame_start = fs;
    bit_valid   = 1'b1;
    @(negedge clk);
    bit_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input int gap, input logic clr_par);
    for (int i = 0; i < 8; i++) begin
      put(d[i], (i == 0));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check_eq("gap_busy", ife.busy, 1);
      end
    end
    clr_count = clr_par;
    put(p, 1'b0);
    clr_count = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    bit_in      = 1'b0;
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    clr_count   = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_data", ife.data_out, 0);
    check_eq("rst_dv", ife.data_valid, 0);
    check_eq("rst_perr", ife.parity_err, 0);
    check_eq("rst_busy", ife.busy, 0);
    check_eq("rst_cnt", ife.err_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0xA5, good even parity.
    put(1'b1, 1'b1);
    check_eq("a5_busy_first", ife.busy, 1);
    for (int i = 1; i < 8; i++) put(((8'hA5 >> i) & 8'h1) != 0, 1'b0);
    put(1'b0, 1'b0);
    check_eq("a5_dv", ife.data_valid, 1);
    check_eq("a5_data", ife.data_out, 32'hA5);
    check_eq("a5_perr", ife.parity_err, 0);
    check_eq("a5_cnt", ife.err_count, 0);
    check_eq("a5_busy_done", ife.busy, 0);
    check_eq("a5_odd_perr", ifo.parity_err, 1);
    check_eq("a5_odd_cnt", ifo.err_count, 1);
    @(negedge clk);
    check_eq("a5_dv_pulse", ife.data_valid, 0);

    // 0xA5 with a bad even parity bit (good for odd mode).
    send_frame(8'hA5, 1'b1, 0, 1'b0);
    check_eq("bad_dv", ife.data_valid, 1);
    check_eq("bad_perr", ife.parity_err, 1);
    check_eq("bad_cnt", ife.err_count, 1);
    check_eq("bad_odd_dv", ifo.data_valid, 1);
    check_eq("bad_odd_perr", ifo.parity_err, 0);
    check_eq("bad_odd_cnt", ifo.err_count, 1);

    // 0x3C with 3-cycle gaps between bits; back-to-back with the previous frame.
    send_frame(8'h3C, 1'b0, 3, 1'b0);
    check_eq("gap_dv", ife.data_valid, 1);
    check_eq("gap_data", ife.data_out, 32'h3C);
    check_eq("gap_perr", ife.parity_err, 0);
    check_eq("gap_odd_cnt", ifo.err_count, 2);
    @(negedge clk);
    check_eq("gap_dv_pulse", ife.data_valid, 0);

    // Restart after 4 bits with a fresh 0xFF frame.
    mark = dv_seen;
    put(1'b1, 1'b1);
    put(1'b0, 1'b0);
    put(1'b1, 1'b0);
    put(1'b1, 1'b0);
    check_eq("rs_no_dv", ife.data_valid, 0);
    send_frame(8'hFF, 1'b0, 0, 1'b0);
    check_eq("rs_dv", ife.data_valid, 1);
    check_eq("rs_data", ife.data_out, 32'hFF);
    check_eq("rs_perr", ife.parity_err, 0);
    check_eq("rs_odd_cnt", ifo.err_count, 3);
    repeat (2) @(negedge clk);
    check_eq("rs_one_pulse", dv_seen - mark, 1);

    // Clear, then saturate the 2-bit counter.
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
    check_eq("clr_cnt", ife.err_count, 0);
    check_eq("clr_odd_cnt", ifo.err_count, 0);
    for (int k = 0; k < 5; k++) begin
      send_frame(8'hA5, 1'b1, 0, 1'b0);
      check_eq("sat_perr", ife.parity_err, 1);
      check_eq("sat_cnt", ife.err_count, (k < 3) ? k + 1 : 3);
    end
    check_eq("sat_odd_cnt", ifo.err_count, 0);

    // Clear coincident with a sixth error: clear wins.
    send_frame(8'hA5, 1'b1, 0, 1'b1);
    check_eq("clrwin_perr", ife.parity_err, 1);
    check_eq("clrwin_cnt", ife.err_count, 0);

    // Reset in the middle of a frame.
    @(negedge clk);
    put(1'b1, 1'b1);
    put(1'b0, 1'b0);
    put(1'b1, 1'b0);
    put(1'b0, 1'b0);
    put(1'b0, 1'b0);
    check_eq("mid_busy", ife.busy, 1);
    check_eq("mid_data_held", ife.data_out, 32'hA5);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_data", ife.data_out, 0);
    check_eq("mid_rst_dv", ife.data_valid, 0);
    check_eq("mid_rst_perr", ife.parity_err, 0);
    check_eq("mid_rst_busy", ife.busy, 0);
    check_eq("mid_rst_cnt", ife.err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mark = dv_seen;
    put(1'b1, 1'b0);
    check_eq("post_busy", ife.busy, 0);
    put(1'b0, 1'b0);
    put(1'b1, 1'b0);
    put(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("post_no_dv", dv_seen - mark, 0);
    check_eq("post_busy_end", ife.busy, 0);
    check_eq("post_data", ife.data_out, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
